// File: rtl/matrix_logic_pkg.sv
// Shared opcode and state encodings for the matrix logic engine.
// Also holds the helper that tells which opcodes need a second operand matrix.
package matrix_logic_pkg;

    typedef enum logic [2:0] {
        OP_ROT_DOWN  = 3'd0,
        OP_ROT_RIGHT = 3'd1,
        OP_ROT_UP    = 3'd2,
        OP_ROT_LEFT  = 3'd3,
        OP_AND_C     = 3'd4,
        OP_XOR_C     = 3'd5,
        OP_AND_M     = 3'd6,
        OP_OR_M      = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

    function automatic logic is_two_operand(input op_e op);
        return (op == OP_AND_M) || (op == OP_OR_M);
    endfunction

endpackage

// File: rtl/row_rotator.sv
// Combinational element rotation of one row by a single element.
// dir=1 moves every element toward the MSB (top element wraps to 0); dir=0 is the inverse.
module row_rotator #(
    parameter int COLS = 8,
    parameter int EW   = 4
) (
    input  logic [COLS*EW-1:0] row,
    input  logic               dir,
    output logic [COLS*EW-1:0] rotated
);

    localparam int RW = COLS * EW;

    logic [RW-1:0] left;
    logic [RW-1:0] right;

    for (genvar gi = 0; gi < COLS; gi++) begin : g_elem
        assign left[gi*EW +: EW]  = row[((gi + COLS - 1) % COLS)*EW +: EW];
        assign right[gi*EW +: EW] = row[((gi + 1) % COLS)*EW +: EW];
    end

    assign rotated = dir ? left : right;

endmodule

// File: rtl/matrix_logic_engine.sv
// Row-streaming matrix engine: loads one or two ROWS x RW matrices, computes all
// result rows in a single cycle, then streams them out with a valid/ready handshake.
module matrix_logic_engine
    import matrix_logic_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int EW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [COLS*EW-1:0] constant,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COLS*EW-1:0] in_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLS*EW-1:0] out_row,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam int            RW       = COLS * EW;
    localparam int            CW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    state_e        state_reg;
    state_e        state_next;
    op_e           op_reg;
    logic [RW-1:0] const_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_inc;
    logic          cnt_last;
    logic          in_fire;
    logic          rot_left;

    logic [RW-1:0] a_mem [ROWS];
    logic [RW-1:0] b_mem [ROWS];
    logic [RW-1:0] r_mem [ROWS];
    logic [ROWS-1:0][RW-1:0] r_next;

    logic          out_valid_reg;
    logic          out_last_reg;
    logic          done_reg;
    logic [RW-1:0] out_row_reg;

    assign cnt_last = (cnt_reg == LAST_ROW);
    assign cnt_inc  = cnt_last ? '0 : cnt_reg + 1'b1;
    assign in_fire  = in_valid && in_ready;
    assign rot_left = (op_reg == OP_ROT_LEFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && cnt_last)
                    state_next = is_two_operand(op_reg) ? ST_LOAD_B : ST_COMPUTE;
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && cnt_last) state_next = ST_COMPUTE;
            end
            ST_COMPUTE: state_next = ST_OUT;
            ST_OUT: begin
                if (out_valid_reg && out_ready && out_last_reg) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // On entering OUT the first row is fetched from the result buffer, which is
    // why out_valid trails COMPUTE by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg        <= OP_ROT_DOWN;
            const_reg     <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_row_reg   <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg    <= op_e'(op);
                        const_reg <= constant;
                        cnt_reg   <= '0;
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (in_fire) cnt_reg <= cnt_inc;
                end
                ST_OUT: begin
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_row_reg   <= r_mem[0];
                        out_last_reg  <= 1'b0;
                    end else if (out_ready) begin
                        if (out_last_reg) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            out_row_reg   <= '0;
                            cnt_reg       <= '0;
                            done_reg      <= 1'b1;
                        end else begin
                            out_row_reg  <= r_mem[cnt_inc];
                            out_last_reg <= (cnt_inc == LAST_ROW);
                            cnt_reg      <= cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffers hold no reset: nothing reaches out_row until a full load and compute.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (state_reg == ST_LOAD_A) a_mem[cnt_reg] <= in_row;
            else                        b_mem[cnt_reg] <= in_row;
        end
        if (state_reg == ST_COMPUTE) begin
            for (int i = 0; i < ROWS; i++) r_mem[i] <= r_next[i];
        end
    end

    function automatic logic [RW-1:0] row_result(
        input op_e           opc,
        input logic [RW-1:0] cur,
        input logic [RW-1:0] prev,
        input logic [RW-1:0] next,
        input logic [RW-1:0] rotated,
        input logic [RW-1:0] other,
        input logic [RW-1:0] cval
    );
        case (opc)
            OP_ROT_DOWN:  return prev;
            OP_ROT_UP:    return next;
            OP_ROT_LEFT:  return rotated;
            OP_ROT_RIGHT: return rotated;
            OP_AND_C:     return cur & cval;
            OP_XOR_C:     return cur ^ cval;
            OP_AND_M:     return cur & other;
            OP_OR_M:      return cur | other;
            default:      return cur;
        endcase
    endfunction

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [RW-1:0] rotated;

        row_rotator #(
            .COLS (COLS),
            .EW   (EW)
        ) u_rot (
            .row     (a_mem[gi]),
            .dir     (rot_left),
            .rotated (rotated)
        );

        assign r_next[gi] = row_result(op_reg, a_mem[gi],
                                       a_mem[(gi + ROWS - 1) % ROWS],
                                       a_mem[(gi + 1) % ROWS],
                                       rotated, b_mem[gi], const_reg);
    end

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_row   = out_row_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_matrix_logic_engine.sv
// Scoreboard bench: the driver queues expected rows from a behavioural matrix model,
// an independent monitor checks every output handshake and stall stability.
module tb_matrix_logic_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int EW   = 4;
    localparam int RW   = COLS * EW;

    typedef logic [RW-1:0] mat_t [ROWS];
    typedef struct {
        logic [RW-1:0] row;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [RW-1:0] constant = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          busy;
    logic          done;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   n_done_exp = 0;
    int   stall_pct = 0;
    exp_t exp_q[$];

    matrix_logic_engine #(
        .ROWS (ROWS),
        .COLS (COLS),
        .EW   (EW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .constant  (constant),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, required handshake", name);
    endtask

    // Reference: whole-matrix rules, element rotation done as arithmetic shifts.
    function automatic logic [RW-1:0] model_row(input logic [2:0] opc, input logic [RW-1:0] c,
                                               input mat_t a, input mat_t b, input int r);
        case (opc)
            3'd0:    return a[(r + ROWS - 1) % ROWS];
            3'd1:    return (a[r] >> EW) | (a[r] << (RW - EW));
            3'd2:    return a[(r + 1) % ROWS];
            3'd3:    return (a[r] << EW) | (a[r] >> (RW - EW));
            3'd4:    return a[r] & c;
            3'd5:    return a[r] ^ c;
            3'd6:    return a[r] & b[r];
            default: return a[r] | b[r];
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    initial begin
        logic          held_valid;
        logic [RW-1:0] held_row;
        logic          held_last;
        exp_t          e;
        held_valid = 1'b0;
        held_row   = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_valid = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (held_valid) begin
                    if (!out_valid) chk("out_valid_dropped", {31'd0, out_valid}, 1);
                    else begin
                        chk("stall_row_stable", out_row, held_row);
                        chk("stall_last_stable", {31'd0, out_last}, {31'd0, held_last});
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_row: got %h, required no output", out_row);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_row", out_row, e.row);
                        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    end
                    held_valid = 1'b0;
                end else if (out_valid) begin
                    held_valid = 1'b1;
                    held_row   = out_row;
                    held_last  = out_last;
                end else begin
                    held_valid = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                fail_timeout("wait_idle");
                return;
            end
        end
    endtask

    task automatic send_row(input logic [RW-1:0] row, input int gap_pct);
        int  n = 0;
        bit  ok;
        in_valid = 1'b0;
        while ($urandom_range(0, 99) < gap_pct) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_row   = row;
        forever begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            n++;
            if (n > 200) begin
                fail_timeout("in_handshake");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] opc, input logic [RW-1:0] c, input mat_t a,
                          input mat_t b, input int gap_pct, input bit chain);
        int n = 0;
        exp_t e;
        if (chain) begin
            while (done !== 1'b1) begin
                @(posedge clk);
                #1;
                n++;
                if (n > 500) begin
                    fail_timeout("wait_done");
                    break;
                end
            end
        end else begin
            wait_idle();
        end
        start    = 1'b1;
        op       = opc;
        constant = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (chain) chk("chain_busy", {31'd0, busy}, 1);
        for (int r = 0; r < ROWS; r++) begin
            e.row  = model_row(opc, c, a, b, r);
            e.last = (r == ROWS - 1);
            exp_q.push_back(e);
        end
        n_done_exp++;
        for (int r = 0; r < ROWS; r++) send_row(a[r], gap_pct);
        if (opc == 3'd6 || opc == 3'd7)
            for (int r = 0; r < ROWS; r++) send_row(b[r], gap_pct);
        chk("compute_no_ready", {31'd0, in_ready}, 0);
        chk("lat_n", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        chk("lat_n1", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        chk("lat_n2", {31'd0, out_valid}, 1);
        $display("op %0d const %h issued, last load then out_valid two edges later", opc, c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t a;
        mat_t b;
        int   d0;

        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_out_row", out_row, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ROT_UP on A[r]=r
        for (int r = 0; r < ROWS; r++) begin a[r] = RW'(r); b[r] = '0; end
        d0 = done_cnt;
        run_op(3'd2, '0, a, b, 0, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rot_up_done_once", RW'(done_cnt - d0), 1);

        // Element rotations
        for (int r = 0; r < ROWS; r++) a[r] = 32'h12345678;
        run_op(3'd3, '0, a, b, 0, 1'b0);
        run_op(3'd1, '0, a, b, 0, 1'b0);

        // XOR with constant, last row included
        for (int r = 0; r < ROWS; r++) a[r] = 32'h0000FFFF;
        run_op(3'd5, 32'hFFFF0000, a, b, 0, 1'b0);

        // OR_M with gaps and stalls; a start during OUT must be ignored
        wait_idle();
        stall_pct = 40;
        for (int r = 0; r < ROWS; r++) begin a[r] = RW'(r); b[r] = 32'h100; end
        run_op(3'd7, '0, a, b, 40, 1'b0);
        start = 1'b1;
        op    = 3'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_out_ignored", {31'd0, busy}, 0);
        stall_pct = 0;

        // Reset during LOAD_B row 3
        wait_idle();
        start = 1'b1;
        op    = 3'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) send_row(RW'(r), 0);
        for (int r = 0; r < 3; r++) send_row(32'h100, 0);
        in_valid = 1'b1;
        in_row   = 32'hDEADBEEF;
        chk("load_b_ready", {31'd0, in_ready}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_out_last", {31'd0, out_last}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_out_row", out_row, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        $display("reset asserted in LOAD_B row 3, buffered data discarded");
        for (int r = 0; r < ROWS; r++) a[r] = 32'hFFFFFFFF;
        run_op(3'd4, 32'h0F0F0F0F, a, b, 0, 1'b0);

        // Start in the done cycle
        for (int r = 0; r < ROWS; r++) begin a[r] = $urandom; b[r] = $urandom; end
        run_op(3'd6, '0, a, b, 0, 1'b0);
        for (int r = 0; r < ROWS; r++) a[r] = $urandom;
        run_op(3'd0, '0, a, b, 0, 1'b1);

        // Random operations, with alternating chained starts
        stall_pct = 30;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < ROWS; r++) begin a[r] = $urandom; b[r] = $urandom; end
            run_op(3'($urandom_range(0, 7)), $urandom, a, b, 25, (k % 2) == 1);
        end

        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", RW'(exp_q.size()), 0);
        chk("done_count", RW'(done_cnt), RW'(n_done_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_logic_engine.md
MATRIX_LOGIC_ENGINE -- requirements
Module: matrix_logic_engine

Interface
REQ-001 Parameter ROWS, default 8: number of matrix rows; must be at least 2.
REQ-002 Parameter COLS, default 8: elements per row; must be at least 2.
REQ-003 Parameter EW, default 4: element width in bits. RW = COLS*EW is the row width.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a new operation; sampled in IDLE only.
REQ-007 op  input  3  opcode, latched on start: 0 ROT_DOWN, 1 ROT_RIGHT, 2 ROT_UP, 3 ROT_LEFT, 4 AND_C, 5 XOR_C, 6 AND_M, 7 OR_M.
REQ-008 constant  input  RW  row constant, latched on start.
REQ-009 in_valid / in_ready  input / output  1 each  input-row handshake.
REQ-010 in_row  input  RW  operand row data.
REQ-011 out_valid / out_ready  output / input  1 each  result-row handshake.
REQ-012 out_row  output  RW  result row data.
REQ-013 out_last  output  1  high with result row ROWS-1.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 done  output  1  one-cycle pulse on completion.

Function
REQ-016 The block SHALL implement the state machine IDLE -> LOAD_A -> (LOAD_B if op is 6 or 7) -> COMPUTE -> OUT -> IDLE.
REQ-017 In IDLE, start=1 SHALL latch op and constant and move to LOAD_A on the next edge; start SHALL be ignored in every other state.
REQ-018 in_ready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-019 A row SHALL transfer on each edge where in_valid && in_ready; the first row transferred is row 0, and a row counter advances 0..ROWS-1.
REQ-020 Loading SHALL leave LOAD_A/LOAD_B after row ROWS-1; the counter then wraps to 0.
REQ-021 COMPUTE SHALL last exactly one cycle and write all ROWS result rows into the result buffer.
REQ-022 Row rotations: ROT_UP gives R[r] = A[(r+1) mod ROWS]; ROT_DOWN gives R[r] = A[(r-1) mod ROWS].
REQ-023 Element rotations, with element 0 at bits EW-1:0: ROT_LEFT rotates every row toward the MSB by EW bits, with the top element wrapping to element 0; ROT_RIGHT is the inverse.
REQ-024 AND_C / XOR_C SHALL give R[r] = A[r] & constant / A[r] ^ constant for all ROWS rows, including the last.
REQ-025 AND_M / OR_M SHALL give R[r] = A[r] & B[r] / A[r] | B[r].
REQ-026 Latency: if the last input handshake is at edge N, COMPUTE occupies cycle N..N+1 and out_valid SHALL rise at edge N+2.
REQ-027 OUT SHALL present rows 0..ROWS-1 in order; out_valid SHALL stay high, and out_row/out_last stable, until out_ready.
REQ-028 On the handshake of row ROWS-1, the block SHALL return to IDLE and pulse done for one cycle; a start in that same done cycle SHALL be accepted.
REQ-029 With out_ready held at 1, the block SHALL stream ROWS rows on consecutive cycles.

Reset
REQ-030 While reset=1, the block SHALL be in IDLE with counter 0 and in_ready, out_valid, out_last, busy, done, out_row all 0; reset mid-operation SHALL discard all buffered data.
REQ-031 Buffer contents need not be cleared, but stale data SHALL never appear with out_valid=1.

Structure
REQ-032 Package matrix_logic_pkg SHALL hold the opcode enum, the state enum and the helper function is_two_operand(op).
REQ-033 Element rotation SHALL be a combinational sub-module row_rotator (parameters COLS, EW; inputs row and dir), instantiated once per row.
REQ-034 The A, B and result buffers SHALL be ROWS x RW register arrays; there is no RW-wide shift of the whole matrix.

Verification (defaults ROWS=8, COLS=8, EW=4)
REQ-035 Test ROT_UP with rows A[r]=r -> outputs 1,2,...,7,0; out_last on the 8th row; done pulses once.
REQ-036 Test ROT_LEFT with every row 0x12345678 -> every output row 0x23456781; ROT_RIGHT on the same input -> 0x81234567.
REQ-037 Test XOR_C with constant 0xFFFF0000 and rows A[r]=0x0000FFFF -> all 8 rows 0xFFFFFFFF, row 7 included.
REQ-038 Test OR_M with A[r]=r and B[r]=0x100 plus random in_valid gaps and out_ready stalls -> outputs 0x100|r, in order, each stable while stalled.
REQ-039 Assert reset during LOAD_B (row 3) -> next cycle all outputs 0; then a fresh AND_C with constant 0x0F0F0F0F on rows 0xFFFFFFFF -> 0x0F0F0F0F.
REQ-040 Pulse start during OUT -> ignored; start asserted in the done cycle -> accepted, and busy stays 1.
